data_sram_confreg: RTL and testbench



---
 rtl/data_sram_confreg_if.sv | 18 +
 rtl/data_sram_confreg.sv | 115 +++++++++++
 tb/tb_data_sram_confreg.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/data_sram_confreg_if.sv
// Data SRAM port between the CPU core (master) and its memory/register responder (slave).
interface data_sram_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata
  );

  modport slave (
    input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
    output data_sram_rdata
  );
endinterface

// File: rtl/data_sram_confreg.sv
// Data SRAM responder: word RAM plus LED/NUM/SWITCH/TIMER register window.
// Fixed one-cycle read latency, no backpressure; writes leave rdata untouched.
module data_sram_confreg #(
  parameter int          RAM_AW  = 14,
  parameter logic [15:0] MMIO_HI = 16'hbfaf
) (
  input  logic        clk,
  input  logic        reset,
  data_sram_if.slave  bus,
  input  logic [7:0]  switch_in,
  output logic [15:0] led,
  output logic [31:0] num_data
);

  localparam logic [13:0] OFF_LED   = 14'h3c00;  // 16'hf000
  localparam logic [13:0] OFF_NUM   = 14'h3c04;  // 16'hf010
  localparam logic [13:0] OFF_SW    = 14'h3c08;  // 16'hf020
  localparam logic [13:0] OFF_TIMER = 14'h3800;  // 16'he000

  logic [31:0]       ram [0:(2**RAM_AW)-1];
  logic [31:0]       timer;
  logic [7:0]        sw_meta;
  logic [7:0]        sw_sync;
  logic [31:0]       rd_val;
  logic [RAM_AW-1:0] idx;
  logic [13:0]       off;
  logic              mmio;
  logic              rd_req;
  logic              wr_req;
  logic              unused_addr_lsb;

  assign idx             = bus.data_sram_addr[RAM_AW+1:2];
  assign off             = bus.data_sram_addr[15:2];
  assign mmio            = (bus.data_sram_addr[31:16] == MMIO_HI);
  assign rd_req          = bus.data_sram_en && (bus.data_sram_we == 4'b0000);
  assign wr_req          = bus.data_sram_en && (bus.data_sram_we != 4'b0000);
  assign unused_addr_lsb = ^bus.data_sram_addr[1:0];

  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] new_v,
                                        input logic [3:0]  we);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++)
      if (we[i]) r[8*i +: 8] = new_v[8*i +: 8];
    return r;
  endfunction

  always_comb begin
    rd_val = 32'h0;
    if (!mmio) begin
      rd_val = ram[idx];
    end else begin
      case (off)
        OFF_LED:   rd_val = {16'h0, led};
        OFF_NUM:   rd_val = num_data;
        OFF_SW:    rd_val = {24'h0, sw_sync};
        OFF_TIMER: rd_val = timer;
        default:   rd_val = 32'h0;
      endcase
    end
  end

  // RAM is deliberately not reset so it can map onto block memory.
  always_ff @(posedge clk) begin
    if (wr_req && !mmio) begin
      for (int i = 0; i < 4; i++)
        if (bus.data_sram_we[i]) ram[idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.data_sram_rdata <= 32'h0;
    end else if (rd_req) begin
      bus.data_sram_rdata <= rd_val;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led      <= 16'h0;
      num_data <= 32'h0;
    end else if (wr_req && mmio) begin
      if (off == OFF_LED) begin
        if (bus.data_sram_we[0]) led[7:0]  <= bus.data_sram_wdata[7:0];
        if (bus.data_sram_we[1]) led[15:8] <= bus.data_sram_wdata[15:8];
      end
      if (off == OFF_NUM)
        num_data <= merge(num_data, bus.data_sram_wdata, bus.data_sram_we);
    end
  end

  // A write beat replaces the increment so the loaded value is seen next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer <= 32'h0;
    end else if (wr_req && mmio && (off == OFF_TIMER)) begin
      timer <= merge(timer, bus.data_sram_wdata, bus.data_sram_we);
    end else begin
      timer <= timer + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_meta <= 8'h0;
      sw_sync <= 8'h0;
    end else begin
      sw_meta <= switch_in;
      sw_sync <= sw_meta;
    end
  end

endmodule

// File: tb/tb_data_sram_confreg.sv
// Directed bench for data_sram_confreg: vector table for RAM traffic plus
// hand-written timer, register-window, switch and reset sequences.
module tb_data_sram_confreg;

  logic        clk;
  logic        reset;
  logic [7:0]  switch_in;
  logic [15:0] led;
  logic [31:0] num_data;

  data_sram_if bus ();

  data_sram_confreg #(.RAM_AW(14), .MMIO_HI(16'hbfaf)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .switch_in (switch_in),
    .led       (led),
    .num_data  (num_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a falling edge; applies one request across the next rising edge.
  task automatic step(input logic en, input logic [3:0] we,
                      input logic [31:0] addr, input logic [31:0] wdata);
    bus.data_sram_en    = en;
    bus.data_sram_we    = we;
    bus.data_sram_addr  = addr;
    bus.data_sram_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 4'hf,    32'h1c000100, 32'h12345678, 32'h00000000};
    vecs[1]  = '{1'b1, 4'h0,    32'h1c000100, 32'h0,        32'h12345678};
    vecs[2]  = '{1'b1, 4'b0010, 32'h1c000100, 32'hAABBCCDD, 32'h12345678};
    vecs[3]  = '{1'b1, 4'h0,    32'h1c000100, 32'h0,        32'h1234CC78};
    vecs[4]  = '{1'b1, 4'hf,    32'h00000000, 32'h1,        32'h1234CC78};
    vecs[5]  = '{1'b1, 4'hf,    32'h00000004, 32'h2,        32'h1234CC78};
    vecs[6]  = '{1'b1, 4'hf,    32'h00000008, 32'h3,        32'h1234CC78};
    vecs[7]  = '{1'b1, 4'h0,    32'h00000000, 32'h0,        32'h00000001};
    vecs[8]  = '{1'b1, 4'h0,    32'h00000004, 32'h0,        32'h00000002};
    vecs[9]  = '{1'b1, 4'h0,    32'h00000008, 32'h0,        32'h00000003};
    vecs[10] = '{1'b0, 4'hx,    32'hxxxxxxxx, 32'hxxxxxxxx, 32'h00000003};
    vecs[11] = '{1'b1, 4'h0,    32'h00000100, 32'h0,        32'h1234CC78};
    vecs[12] = '{1'b1, 4'h0,    32'h1c000102, 32'h0,        32'h1234CC78};

    reset     = 1'b1;
    switch_in = 8'h00;
    bus.data_sram_en    = 1'b0;
    bus.data_sram_we    = 4'h0;
    bus.data_sram_addr  = 32'h0;
    bus.data_sram_wdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    check("reset_rdata", bus.data_sram_rdata, 32'h0);
    check("reset_led",   {16'h0, led},        32'h0);
    check("reset_num",   num_data,            32'h0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      check($sformatf("vec%0d_rdata", i), bus.data_sram_rdata, vecs[i].exp_rdata);
    end

    // Timer: load, one idle cycle, read, gap, read across the wrap.
    step(1'b1, 4'hf, 32'hbfafe000, 32'hfffffffe);
    check("timer_wr_rdata_held", bus.data_sram_rdata, 32'h1234CC78);
    step(1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b1, 4'h0, 32'hbfafe000, 32'h0);
    check("timer_rd_pre_wrap", bus.data_sram_rdata, 32'hffffffff);
    step(1'b0, 4'h0, 32'h0, 32'h0);
    check("timer_idle_hold", bus.data_sram_rdata, 32'hffffffff);
    step(1'b1, 4'h0, 32'hbfafe000, 32'h0);
    check("timer_rd_post_wrap", bus.data_sram_rdata, 32'h00000001);

    // LED, NUM, unmapped offsets.
    step(1'b1, 4'hf, 32'hbfaff000, 32'h12345A5A);
    check("led_write", {16'h0, led}, 32'h00005A5A);
    step(1'b1, 4'b1100, 32'hbfaff000, 32'hffffffff);
    check("led_upper_lanes_ignored", {16'h0, led}, 32'h00005A5A);
    step(1'b1, 4'h0, 32'hbfaff000, 32'h0);
    check("led_read", bus.data_sram_rdata, 32'h00005A5A);
    step(1'b1, 4'hf, 32'hbfaff010, 32'hDEADBEEF);
    check("num_write", num_data, 32'hDEADBEEF);
    step(1'b1, 4'h0, 32'hbfaff010, 32'h0);
    check("num_read", bus.data_sram_rdata, 32'hDEADBEEF);
    step(1'b1, 4'hf, 32'hbfaf1234, 32'hffffffff);
    step(1'b1, 4'h0, 32'hbfaf1234, 32'h0);
    check("unmapped_read", bus.data_sram_rdata, 32'h0);

    // Switch: two-flop synchronizer latency, writes ignored.
    switch_in = 8'hC3;
    step(1'b1, 4'h0, 32'hbfaff020, 32'h0);
    check("switch_rd_t0", bus.data_sram_rdata, 32'h0);
    step(1'b1, 4'hf, 32'hbfaff020, 32'h000000ff);
    check("switch_wr_rdata_held", bus.data_sram_rdata, 32'h0);
    step(1'b1, 4'h0, 32'hbfaff020, 32'h0);
    check("switch_rd_t2", bus.data_sram_rdata, 32'h000000C3);

    // Reset with a response just registered: everything clears asynchronously.
    bus.data_sram_en    = 1'b1;
    bus.data_sram_we    = 4'h0;
    bus.data_sram_addr  = 32'h1c000100;
    @(posedge clk);
    #1;
    check("rd_before_reset", bus.data_sram_rdata, 32'h1234CC78);
    #1 reset = 1'b1;
    #1;
    check("async_reset_rdata", bus.data_sram_rdata, 32'h0);
    check("async_reset_led",   {16'h0, led},        32'h0);
    check("async_reset_num",   num_data,            32'h0);
    @(negedge clk);
    bus.data_sram_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 4'h0, 32'hbfafe000, 32'h0);
    check("timer_after_reset", bus.data_sram_rdata, 32'h0);
    step(1'b1, 4'h0, 32'h1c000100, 32'h0);
    check("ram_kept_over_reset", bus.data_sram_rdata, 32'h1234CC78);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
